// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs and pipeline strobes.
// The master drives the pipeline-side inputs; the slave is the controller.
interface hazard_ctrl_if;
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic        uses_rt_d;
  logic        memread_e;
  logic        regwrite_e;
  logic [4:0]  writereg_e;
  logic        branch_taken;
  logic        stall_pc;
  logic        stall_ifid;
  logic        flush_ifid;
  logic        nop;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output rs_d, rt_d, uses_rt_d,
    output memread_e, regwrite_e,
    output writereg_e, branch_taken,
    input  stall_pc, stall_ifid,
    input  flush_ifid, nop,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_d, rt_d, uses_rt_d,
    input  memread_e, regwrite_e,
    input  writereg_e, branch_taken,
    output stall_pc, stall_ifid,
    output flush_ifid, nop,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall and taken-branch flush controller for the 5-stage pipe.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hif
);
  typedef enum logic {RUN, LSTALL} state_t;

  localparam logic [1:0] CNT_INIT =
    2'(LOAD_STALL_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       hazard;
  logic       rs_hit, rt_hit;
  logic       sp, si, fl, np;

  assign rs_hit = hif.writereg_e == hif.rs_d;
  assign rt_hit = hif.uses_rt_d &
                  (hif.writereg_e == hif.rt_d);

  assign hazard = hif.memread_e & hif.regwrite_e &
                  (hif.writereg_e != 5'd0) &
                  (rs_hit | rt_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sp      = 1'b0;
    si      = 1'b0;
    fl      = 1'b0;
    np      = 1'b0;
    unique case (state)
      RUN: begin
        if (hif.branch_taken) begin
          fl = 1'b1;
          np = 1'b1;
        end else if (hazard) begin
          sp = 1'b1;
          si = 1'b1;
          np = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_n = LSTALL;
            cnt_n   = CNT_INIT;
          end
        end
      end
      LSTALL: begin
        if (hif.branch_taken) begin
          fl      = 1'b1;
          np      = 1'b1;
          cnt_n   = 2'd0;
          state_n = RUN;
        end else begin
          sp    = 1'b1;
          si    = 1'b1;
          np    = 1'b1;
          cnt_n = cnt - 2'd1;
          if (cnt == 2'd1) state_n = RUN;
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = 2'd0;
      end
    endcase
  end

  // Strobes are gated so nothing leaks out while reset is held.
  assign hif.stall_pc   = sp & rst_n;
  assign hif.stall_ifid = si & rst_n;
  assign hif.flush_ifid = fl & rst_n;
  assign hif.nop        = np & rst_n;

`ifdef HAZARD_PERF_EN
  logic [31:0] scnt, fcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt <= 32'd0;
      fcnt <= 32'd0;
    end else begin
      if (hif.stall_pc && scnt != '1)
        scnt <= scnt + 32'd1;
      if (hif.flush_ifid && fcnt != '1)
        fcnt <= fcnt + 32'd1;
    end
  end

  assign hif.stall_cnt = scnt;
  assign hif.flush_cnt = fcnt;
`else
  assign hif.stall_cnt = 32'd0;
  assign hif.flush_cnt = 32'd0;
`endif
endmodule
